// File: rtl/aes_spi_stream_ctrl.sv
// aes_spi_stream_ctrl: session controller between the SPI frame interface
// and the AES cores. Accepts key, config, optional IV and N data frames,
// runs the blocks one at a time in ECB or CBC mode and queues the results
// in an OUT_DEPTH-entry FIFO for the SPI tx side.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   rx_valid, rx_frame    received frame strobe and payload (KEY_W+2 bits)
//   key_out, nk, nr       key and round parameters for key expansion
//   core_start, core_in   one-block start pulse and cipher input
//   core_done, core_out   cipher completion pulse and result
//   tx_valid, tx_data     FIFO not empty, FIFO head
//   tx_taken              pop request (ignored when FIFO empty)
//   busy                  session in progress (state != S_KEY)
//   blocks_done           results pushed this session
//   err_cfg, err_ovf      sticky config error, dropped data frame
module aes_spi_stream_ctrl #(
  parameter int unsigned BLK_W     = 128,
  parameter int unsigned KEY_W     = 256,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [KEY_W+1:0]   rx_frame,
  output logic [KEY_W-1:0]   key_out,
  output logic [3:0]         nk,
  output logic [3:0]         nr,
  output logic               core_start,
  output logic [BLK_W-1:0]   core_in,
  input  logic               core_done,
  input  logic [BLK_W-1:0]   core_out,
  output logic               tx_valid,
  output logic [BLK_W-1:0]   tx_data,
  input  logic               tx_taken,
  output logic               busy,
  output logic [CNT_W-1:0]   blocks_done,
  output logic               err_cfg,
  output logic               err_ovf
);

  localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [1:0] S_KEY = 2'd0;
  localparam logic [1:0] S_CFG = 2'd1;
  localparam logic [1:0] S_IV  = 2'd2;
  localparam logic [1:0] S_RUN = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  n_blocks, n_nxt;
  logic              cbc, cbc_nxt;
  logic [BLK_W-1:0]  chain, chain_nxt;
  logic              skid_full, skid_full_nxt;
  logic [BLK_W-1:0]  skid_data, skid_data_nxt;
  logic              in_flight, in_flight_nxt;
  logic [KEY_W-1:0]  key_nxt;
  logic [3:0]        nk_nxt, nr_nxt;
  logic              core_start_nxt;
  logic [BLK_W-1:0]  core_in_nxt;
  logic [CNT_W-1:0]  blocks_nxt;
  logic              err_cfg_nxt, err_ovf_nxt, busy_nxt;
  logic              tx_valid_nxt;
  logic [BLK_W-1:0]  tx_data_nxt;

  logic [BLK_W-1:0]  mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [FCNT_W-1:0] fifo_cnt, fifo_cnt_nxt;
  logic              push, pop;
  logic              cand_valid;
  logic [BLK_W-1:0]  cand_data;

  // Next-state, datapath and FIFO bookkeeping
  always_comb begin
    state_nxt      = state;
    n_nxt          = n_blocks;
    cbc_nxt        = cbc;
    chain_nxt      = chain;
    skid_full_nxt  = skid_full;
    skid_data_nxt  = skid_data;
    in_flight_nxt  = in_flight;
    key_nxt        = key_out;
    nk_nxt         = nk;
    nr_nxt         = nr;
    core_start_nxt = 1'b0;
    core_in_nxt    = core_in;
    blocks_nxt     = blocks_done;
    err_cfg_nxt    = err_cfg;
    err_ovf_nxt    = err_ovf;
    push           = 1'b0;
    // A frame arriving while the skid is empty may launch straight away
    cand_valid     = skid_full | rx_valid;
    cand_data      = skid_full ? skid_data : rx_frame[BLK_W-1:0];

    case (state)
      S_KEY: begin
        if (rx_valid) begin
          if (rx_frame[KEY_W+1:KEY_W] == 2'b11) begin
            err_cfg_nxt = 1'b1;
          end else begin
            case (rx_frame[KEY_W+1:KEY_W])
              2'b00:   begin nk_nxt = 4'd4; nr_nxt = 4'd10; end
              2'b01:   begin nk_nxt = 4'd6; nr_nxt = 4'd12; end
              default: begin nk_nxt = 4'd8; nr_nxt = 4'd14; end
            endcase
            key_nxt     = rx_frame[KEY_W-1:0];
            err_cfg_nxt = 1'b0;
            err_ovf_nxt = 1'b0;
            blocks_nxt  = '0;
            state_nxt   = S_CFG;
          end
        end
      end
      S_CFG: begin
        if (rx_valid) begin
          if (rx_frame[CNT_W-1:0] == '0) begin
            err_cfg_nxt = 1'b1;
            state_nxt   = S_KEY;
          end else begin
            n_nxt   = rx_frame[CNT_W-1:0];
            cbc_nxt = rx_frame[CNT_W];
            if (rx_frame[CNT_W]) begin
              state_nxt = S_IV;
            end else begin
              chain_nxt = '0;
              state_nxt = S_RUN;
            end
          end
        end
      end
      S_IV: begin
        if (rx_valid) begin
          chain_nxt = rx_frame[BLK_W-1:0];
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (rx_valid && skid_full) err_ovf_nxt = 1'b1;
        // At most one block in flight, so a free slot now is still free at done
        if (cand_valid && !in_flight && (fifo_cnt < FCNT_W'(OUT_DEPTH))) begin
          core_start_nxt = 1'b1;
          core_in_nxt    = cbc ? (cand_data ^ chain) : cand_data;
          in_flight_nxt  = 1'b1;
          skid_full_nxt  = 1'b0;
        end else if (rx_valid && !skid_full) begin
          skid_full_nxt = 1'b1;
          skid_data_nxt = rx_frame[BLK_W-1:0];
        end
        if (core_done && in_flight) begin
          push          = 1'b1;
          in_flight_nxt = 1'b0;
          if (cbc) chain_nxt = core_out;
          blocks_nxt = blocks_done + CNT_W'(1);
          if (blocks_nxt == n_blocks) begin
            state_nxt     = S_KEY;
            skid_full_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = S_KEY;
    endcase

    pop          = tx_taken && (fifo_cnt != '0);
    fifo_cnt_nxt = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
    rd_ptr_nxt   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    tx_valid_nxt = (fifo_cnt_nxt != '0);
    // Head after this edge: the incoming result if it lands in an empty queue
    if (fifo_cnt_nxt == '0)
      tx_data_nxt = tx_data;
    else if ((fifo_cnt == '0) || (pop && (fifo_cnt == FCNT_W'(1))))
      tx_data_nxt = core_out;
    else
      tx_data_nxt = mem[rd_ptr_nxt];
    busy_nxt = (state_nxt != S_KEY);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_KEY;
      n_blocks    <= '0;
      cbc         <= 1'b0;
      chain       <= '0;
      skid_full   <= 1'b0;
      skid_data   <= '0;
      in_flight   <= 1'b0;
      key_out     <= '0;
      nk          <= '0;
      nr          <= '0;
      core_start  <= 1'b0;
      core_in     <= '0;
      blocks_done <= '0;
      err_cfg     <= 1'b0;
      err_ovf     <= 1'b0;
      busy        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
    end else begin
      state       <= state_nxt;
      n_blocks    <= n_nxt;
      cbc         <= cbc_nxt;
      chain       <= chain_nxt;
      skid_full   <= skid_full_nxt;
      skid_data   <= skid_data_nxt;
      in_flight   <= in_flight_nxt;
      key_out     <= key_nxt;
      nk          <= nk_nxt;
      nr          <= nr_nxt;
      core_start  <= core_start_nxt;
      core_in     <= core_in_nxt;
      blocks_done <= blocks_nxt;
      err_cfg     <= err_cfg_nxt;
      err_ovf     <= err_ovf_nxt;
      busy        <= busy_nxt;
      wr_ptr      <= wr_ptr + PTR_W'(push);
      rd_ptr      <= rd_ptr_nxt;
      fifo_cnt    <= fifo_cnt_nxt;
      tx_valid    <= tx_valid_nxt;
      tx_data     <= tx_data_nxt;
    end
  end

  // Result storage; contents are meaningless once the pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= core_out;
  end

endmodule

// File: tb/tb_aes_spi_stream_ctrl.sv
// Bench for aes_spi_stream_ctrl: mock cipher core (out = in ^ key[127:0]),
// table-driven key decode checks, hand sequences for CBC chaining, overflow,
// FIFO back-pressure and mid-session reset, plus randomized sessions.
module tb_aes_spi_stream_ctrl;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned KEY_W = 256;
  localparam int unsigned FRM_W = KEY_W + 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned OUT_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_valid;
  logic [FRM_W-1:0] rx_frame;
  logic [KEY_W-1:0] key_out;
  logic [3:0] nk, nr;
  logic core_start;
  logic [BLK_W-1:0] core_in;
  logic core_done;
  logic [BLK_W-1:0] core_out;
  logic tx_valid;
  logic [BLK_W-1:0] tx_data;
  logic tx_taken;
  logic busy;
  logic [CNT_W-1:0] blocks_done;
  logic err_cfg, err_ovf;

  always #5 clk = ~clk;

  aes_spi_stream_ctrl #(.BLK_W(BLK_W), .KEY_W(KEY_W), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_frame(rx_frame),
    .key_out(key_out), .nk(nk), .nr(nr), .core_start(core_start), .core_in(core_in),
    .core_done(core_done), .core_out(core_out), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_taken(tx_taken), .busy(busy), .blocks_done(blocks_done),
    .err_cfg(err_cfg), .err_ovf(err_ovf)
  );

  int total = 0;
  int bad = 0;
  int mock_lat = 4;
  int n_start = 0;
  int tx_mode = 0;
  bit mbusy;
  int mcnt;
  logic [BLK_W-1:0] cap;
  logic [BLK_W-1:0] dq[$], exp_cin[$], exp_out[$], cin_q[$], got_q[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Mock cipher core: fixed latency, result = input ^ low key half
  initial begin
    core_done = 1'b0; core_out = '0; mbusy = 1'b0; mcnt = 0; cap = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (mbusy) begin
        mcnt--;
        if (mcnt == 0) begin
          mbusy = 1'b0;
          core_done = 1'b1;
          core_out = cap ^ key_out[BLK_W-1:0];
          if (rst_n && busy) chk("core_in_stable", 256'(core_in), 256'(cap));
        end
      end else if (core_start) begin
        cap = core_in;
        cin_q.push_back(core_in);
        n_start++;
        mbusy = 1'b1;
        mcnt = mock_lat;
      end
    end
  end

  // Pop monitor
  initial forever begin
    @(negedge clk);
    if (tx_valid && tx_taken) got_q.push_back(tx_data);
  end

  // tx_taken driver: 0 = hold, 1 = always take, else random
  initial begin
    tx_taken = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (tx_mode)
        0: tx_taken = 1'b0;
        1: tx_taken = 1'b1;
        default: tx_taken = 1'($urandom % 2);
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [FRM_W-1:0] f);
    rx_frame = f; rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // Reference: ECB encrypts each frame, CBC xors with previous ciphertext (IV first)
  task automatic model(input logic [BLK_W-1:0] klo, input bit cbc, input logic [BLK_W-1:0] iv);
    logic [BLK_W-1:0] prev, x, y;
    exp_cin.delete(); exp_out.delete();
    prev = iv;
    foreach (dq[i]) begin
      x = cbc ? (dq[i] ^ prev) : dq[i];
      y = x ^ klo;
      exp_cin.push_back(x);
      exp_out.push_back(y);
      prev = y;
    end
  endtask

  task automatic wait_start(input int k, input string tag);
    int c = 0;
    while (n_start < k && c < 400) begin cyc(1); c++; end
    chk({tag, "_start_count"}, 256'(n_start), 256'(k));
  endtask

  task automatic wait_idle(input int n, input string tag);
    int c = 0;
    while ((busy || got_q.size() < n) && c < 4000) begin cyc(1); c++; end
    chk({tag, "_busy_fall"}, 256'(busy), 256'(0));
    chk({tag, "_blocks_done"}, 256'(blocks_done), 256'(n));
  endtask

  task automatic cmp_queues(input string tag);
    chk({tag, "_n_out"}, 256'(got_q.size()), 256'(exp_out.size()));
    chk({tag, "_n_cin"}, 256'(cin_q.size()), 256'(exp_cin.size()));
    for (int i = 0; i < exp_out.size() && i < got_q.size(); i++)
      chk({tag, "_tx_data"}, 256'(got_q[i]), 256'(exp_out[i]));
    for (int i = 0; i < exp_cin.size() && i < cin_q.size(); i++)
      chk({tag, "_core_in"}, 256'(cin_q[i]), 256'(exp_cin[i]));
  endtask

  task automatic new_run(input int lat, input int txm);
    mock_lat = lat; tx_mode = txm; n_start = 0;
    cin_q.delete(); got_q.delete();
  endtask

  // Full session with data frames from dq, paced so the skid never overflows
  task automatic session(input logic [1:0] code, input logic [255:0] key, input bit cbc,
                         input logic [BLK_W-1:0] iv, input int lat, input int txm, input string tag);
    int n;
    n = dq.size();
    new_run(lat, txm);
    send({code, key});
    chk({tag, "_nk"}, 256'(nk), 256'(4 + 2 * int'(code)));
    chk({tag, "_nr"}, 256'(nr), 256'(10 + 2 * int'(code)));
    send(FRM_W'({cbc, CNT_W'(n)}));
    if (cbc) send(FRM_W'(iv));
    model(key[BLK_W-1:0], cbc, iv);
    for (int i = 0; i < n; i++) begin
      wait_start(i, tag);
      send(FRM_W'(dq[i]));
    end
    wait_idle(n, tag);
    chk({tag, "_err_ovf"}, 256'(err_ovf), 256'(0));
    chk({tag, "_err_cfg"}, 256'(err_cfg), 256'(0));
    cmp_queues(tag);
  endtask

  typedef struct {
    logic [1:0] code;
    logic [3:0] nk;
    logic [3:0] nr;
    logic       err;
    logic       busy;
  } kvec_t;

  initial begin
    kvec_t kv[4];
    logic [255:0] k, last_key;
    logic [BLK_W-1:0] ones;
    ones = '1;

    rst_n = 1'b0; rx_valid = 1'b0; rx_frame = '0;
    cyc(3);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_tx_valid", 256'(tx_valid), 256'(0));
    chk("rst_tx_data", 256'(tx_data), 256'(0));
    chk("rst_key_out", 256'(key_out), 256'(0));
    chk("rst_nk", 256'(nk), 256'(0));
    chk("rst_nr", 256'(nr), 256'(0));
    chk("rst_core_start", 256'(core_start), 256'(0));
    chk("rst_core_in", 256'(core_in), 256'(0));
    chk("rst_blocks_done", 256'(blocks_done), 256'(0));
    chk("rst_err_cfg", 256'(err_cfg), 256'(0));
    chk("rst_err_ovf", 256'(err_ovf), 256'(0));
    rst_n = 1'b1;
    cyc(1);

    // Key code decode table; each valid key is followed by an N=0 config
    kv[0] = '{2'b00, 4'd4, 4'd10, 1'b0, 1'b1};
    kv[1] = '{2'b01, 4'd6, 4'd12, 1'b0, 1'b1};
    kv[2] = '{2'b10, 4'd8, 4'd14, 1'b0, 1'b1};
    kv[3] = '{2'b11, 4'd8, 4'd14, 1'b1, 1'b0};
    last_key = '0;
    for (int i = 0; i < 4; i++) begin
      k = rnd256();
      send({kv[i].code, k});
      if (kv[i].err == 1'b0) last_key = k;
      chk("kt_nk", 256'(nk), 256'(kv[i].nk));
      chk("kt_nr", 256'(nr), 256'(kv[i].nr));
      chk("kt_err_cfg", 256'(err_cfg), 256'(kv[i].err));
      chk("kt_busy", 256'(busy), 256'(kv[i].busy));
      chk("kt_key_out", 256'(key_out), last_key);
      if (kv[i].busy) begin
        send(FRM_W'(0));
        chk("kt_n0_err_cfg", 256'(err_cfg), 256'(1));
        chk("kt_n0_busy", 256'(busy), 256'(0));
      end
    end

    // CBC, IV=0, two zero blocks, core output = ~input
    dq.delete(); dq.push_back('0); dq.push_back('0);
    session(2'b00, {128'h0, ones}, 1'b1, '0, 10, 1, "cbc0");
    chk("cbc0_cin0", 256'(cin_q[0]), 256'(0));
    chk("cbc0_cin1", 256'(cin_q[1]), 256'(ones));
    chk("cbc0_tx0", 256'(got_q[0]), 256'(ones));
    chk("cbc0_tx1", 256'(got_q[1]), 256'(0));

    // Slow core, three back-to-back frames: third dropped until resent
    dq.delete();
    for (int i = 0; i < 3; i++) dq.push_back(BLK_W'(rnd256()));
    k = rnd256();
    new_run(50, 1);
    send({2'b00, k});
    send(FRM_W'({1'b0, CNT_W'(3)}));
    model(k[BLK_W-1:0], 1'b0, '0);
    send(FRM_W'(dq[0])); send(FRM_W'(dq[1])); send(FRM_W'(dq[2]));
    chk("ovf_err_ovf", 256'(err_ovf), 256'(1));
    cyc(150);
    chk("ovf_blocks_stuck", 256'(blocks_done), 256'(2));
    chk("ovf_busy_held", 256'(busy), 256'(1));
    chk("ovf_starts", 256'(n_start), 256'(2));
    send(FRM_W'(dq[2]));
    wait_idle(3, "ovf");
    chk("ovf_err_sticky", 256'(err_ovf), 256'(1));
    cmp_queues("ovf");

    // FIFO back-pressure: no pops, N=OUT_DEPTH+2
    dq.delete();
    for (int i = 0; i < OUT_DEPTH + 2; i++) dq.push_back(BLK_W'(rnd256()));
    k = rnd256();
    new_run(3, 0);
    send({2'b01, k});
    send(FRM_W'({1'b0, CNT_W'(OUT_DEPTH + 2)}));
    model(k[BLK_W-1:0], 1'b0, '0);
    for (int i = 0; i <= OUT_DEPTH; i++) begin
      wait_start(i, "bp");
      send(FRM_W'(dq[i]));
    end
    cyc(30);
    chk("bp_starts_full", 256'(n_start), 256'(OUT_DEPTH));
    chk("bp_blocks_full", 256'(blocks_done), 256'(OUT_DEPTH));
    chk("bp_tx_valid", 256'(tx_valid), 256'(1));
    tx_mode = 1; cyc(1); tx_mode = 0;
    cyc(10);
    chk("bp_starts_after_pop", 256'(n_start), 256'(OUT_DEPTH + 1));
    chk("bp_one_pop", 256'(got_q.size()), 256'(1));
    tx_mode = 1;
    wait_start(OUT_DEPTH + 1, "bp");
    send(FRM_W'(dq[OUT_DEPTH + 1]));
    wait_idle(OUT_DEPTH + 2, "bp");
    cmp_queues("bp");

    // Randomized sessions
    for (int s = 0; s < 5; s++) begin
      int n;
      n = int'($urandom_range(1, 6));
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(BLK_W'(rnd256()));
      session(2'($urandom_range(0, 2)), rnd256(), 1'($urandom % 2), BLK_W'(rnd256()),
              int'($urandom_range(2, 8)), 2, "rnd");
    end

    // Reset while a block is in flight
    new_run(10, 1);
    send({2'b10, rnd256()});
    send(FRM_W'({1'b0, CNT_W'(2)}));
    send(FRM_W'(BLK_W'(rnd256())));
    wait_start(1, "mrst");
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 256'(busy), 256'(0));
    chk("mrst_key_out", 256'(key_out), 256'(0));
    chk("mrst_nk", 256'(nk), 256'(0));
    chk("mrst_core_start", 256'(core_start), 256'(0));
    chk("mrst_tx_valid", 256'(tx_valid), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(20);
    chk("mrst_late_done_tx_valid", 256'(tx_valid), 256'(0));
    chk("mrst_late_done_blocks", 256'(blocks_done), 256'(0));
    chk("mrst_late_done_pops", 256'(got_q.size()), 256'(0));
    chk("mrst_busy_after", 256'(busy), 256'(0));

    // Recovery session after reset
    dq.delete();
    for (int i = 0; i < 3; i++) dq.push_back(BLK_W'(rnd256()));
    session(2'b00, rnd256(), 1'b1, BLK_W'(rnd256()), 5, 2, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
